// File: rtl/fpu_serial_pkg.sv
// Shared state type and tag encodings for the serial FPU front end.
package fpu_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        SEND = 2'd2
    } state_t;

    // Input tags, truncated to the configured tag width where used.
    localparam logic [31:0] TAG_IDLE = 32'h0000_0000;
    localparam logic [31:0] TAG_EXEC = 32'hFFFF_FFFF;

    // Output tags.
    localparam logic [1:0] OUT_NONE  = 2'd0;
    localparam logic [1:0] OUT_CHUNK = 2'd1;
    localparam logic [1:0] OUT_LAST  = 2'd2;

endpackage

// File: rtl/fpu_serial_frontend_chunk_shift_reg.sv
// Chunk-wide left shift register, MSB chunk first, with optional parallel load.
module chunk_shift_reg
    import fpu_serial_pkg::*;
#(
    parameter int CHUNK_W = 8,
    parameter int DATA_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_en,
    input  logic [CHUNK_W-1:0] chunk_in,
    input  logic               par_en,
    input  logic [DATA_W-1:0]  par_in,
    output logic [DATA_W-1:0]  value
);

    logic [DATA_W-1:0] r_value;
    logic [DATA_W-1:0] w_shifted;

    // Keeping the low DATA_W bits of {value, chunk} drops the oldest chunk,
    // which also covers the single-chunk case without a special branch.
    assign w_shifted = DATA_W'({r_value, chunk_in});

    // Parallel load has priority over shifting.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_value <= '0;
        end else if (par_en) begin
            r_value <= par_in;
        end else if (load_en) begin
            r_value <= w_shifted;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/fpu_serial_frontend.sv
// Pin-level front end: tagged operand chunks in, launch the core, result chunks out.
module fpu_serial_frontend
    import fpu_serial_pkg::*;
#(
    parameter int CHUNK_W = 8,
    parameter int DATA_W  = 16,
    parameter int NUM_OPS = 2,
    parameter int TAG_W   = 2,
    parameter int OP_W    = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHUNK_W-1:0]        in_val,
    input  logic [TAG_W-1:0]          in_tag,
    output logic [CHUNK_W-1:0]        out_val,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      ready,
    output logic                      busy_err,
    output logic                      core_start,
    output logic [OP_W-1:0]           core_op,
    output logic [NUM_OPS*DATA_W-1:0] core_operands,
    input  logic                      core_done,
    input  logic [DATA_W-1:0]         core_result
);

    localparam int CHUNKS = DATA_W / CHUNK_W;
    localparam int CNT_W  = $clog2(CHUNKS + 1);

    localparam logic [TAG_W-1:0] L_TAG_IDLE  = TAG_IDLE[TAG_W-1:0];
    localparam logic [TAG_W-1:0] L_TAG_EXEC  = TAG_EXEC[TAG_W-1:0];
    localparam logic [CNT_W-1:0] L_CNT_LAST  = CNT_W'(CHUNKS - 1);
    localparam logic [TAG_W-1:0] L_FIRST_TAG = (CHUNKS == 1) ? TAG_W'(OUT_LAST) : TAG_W'(OUT_CHUNK);

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      w_tag_active;
    logic                      w_exec;
    logic                      w_exec_accept;
    logic                      w_exec_reject;
    logic                      w_done_accept;
    logic                      w_send_step;
    logic [NUM_OPS*DATA_W-1:0] w_opnd_flat;
    logic [DATA_W-1:0]         w_res_value;

    logic [CNT_W-1:0]          r_cnt;
    logic [TAG_W-1:0]          r_out_tag;
    logic                      r_core_start;
    logic [OP_W-1:0]           r_core_op;
    logic [NUM_OPS*DATA_W-1:0] r_core_operands;
    logic                      r_busy_err;

    assign w_tag_active = (in_tag != L_TAG_IDLE);
    assign w_exec       = (in_tag == L_TAG_EXEC);
    assign w_send_step  = (r_state == SEND);

    // Operand k shifts whenever its tag is on the bus, in any state.
    for (genvar k = 0; k < NUM_OPS; k++) begin : g_opnd
        logic w_load;
        assign w_load = w_tag_active && (in_tag == TAG_W'(k + 1));

        chunk_shift_reg #(
            .CHUNK_W (CHUNK_W),
            .DATA_W  (DATA_W)
        ) u_opnd (
            .clock    (clock),
            .reset    (reset),
            .load_en  (w_load),
            .chunk_in (in_val),
            .par_en   (1'b0),
            .par_in   ({DATA_W{1'b0}}),
            .value    (w_opnd_flat[k*DATA_W +: DATA_W])
        );
    end

    // Result register: loaded on core_done, drained one chunk per SEND cycle.
    // Zeros shift in, so it reads zero whenever no result is being sent.
    chunk_shift_reg #(
        .CHUNK_W (CHUNK_W),
        .DATA_W  (DATA_W)
    ) u_result (
        .clock    (clock),
        .reset    (reset),
        .load_en  (w_send_step),
        .chunk_in ({CHUNK_W{1'b0}}),
        .par_en   (w_done_accept),
        .par_in   (core_result),
        .value    (w_res_value)
    );

    // Next-state and command decode.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_state_next  = r_state;
        w_exec_accept = 1'b0;
        w_exec_reject = 1'b0;
        w_done_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_exec) begin
                    w_exec_accept = 1'b1;
                    w_state_next  = BUSY;
                end
            end
            BUSY: begin
                w_exec_reject = w_exec;
                if (core_done) begin
                    w_done_accept = 1'b1;
                    w_state_next  = SEND;
                end
            end
            SEND: begin
                w_exec_reject = w_exec;
                if (r_cnt == L_CNT_LAST) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Launch pulse, opcode/operand snapshot and sticky reject flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_core_start    <= 1'b0;
            r_core_op       <= '0;
            r_core_operands <= '0;
            r_busy_err      <= 1'b0;
        end else begin
            r_core_start <= w_exec_accept;
            if (w_exec_accept) begin
                r_core_op       <= in_val[OP_W-1:0];
                r_core_operands <= w_opnd_flat;
                r_busy_err      <= 1'b0;
            end else if (w_exec_reject) begin
                r_busy_err <= 1'b1;
            end
        end
    end

    // Chunk counter and output tag; r_cnt is the index of the chunk on the bus.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_out_tag <= TAG_W'(OUT_NONE);
        end else if (w_done_accept) begin
            r_cnt     <= '0;
            r_out_tag <= L_FIRST_TAG;
        end else if (w_send_step) begin
            if (r_cnt == L_CNT_LAST) begin
                r_out_tag <= TAG_W'(OUT_NONE);
            end else begin
                r_cnt     <= r_cnt + CNT_W'(1);
                r_out_tag <= (r_cnt + CNT_W'(1) == L_CNT_LAST) ? TAG_W'(OUT_LAST) : TAG_W'(OUT_CHUNK);
            end
        end
    end

    assign ready         = (r_state == IDLE);
    assign out_val       = CHUNK_W'(w_res_value >> (DATA_W - CHUNK_W));
    assign out_tag       = r_out_tag;
    assign busy_err      = r_busy_err;
    assign core_start    = r_core_start;
    assign core_op       = r_core_op;
    assign core_operands = r_core_operands;

endmodule

// File: tb/tb_fpu_serial_frontend.sv
// Scoreboard bench for fpu_serial_frontend: a timeline model predicts launches,
// result chunks, ready and busy_err; a monitor compares on every falling edge.
`timescale 1ns/1ps
module tb_fpu_serial_frontend;

    localparam int CHUNK_W = 8;
    localparam int DATA_W  = 16;
    localparam int NUM_OPS = 2;
    localparam int TAG_W   = 2;
    localparam int OP_W    = 4;
    localparam int CHUNKS  = DATA_W / CHUNK_W;
    localparam int BIG     = 1 << 30;
    localparam logic [TAG_W-1:0] T_EXEC = '1;

    typedef struct {
        int                 cyc;
        logic [CHUNK_W-1:0] val;
        logic [TAG_W-1:0]   tag;
    } chunk_t;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic [CHUNK_W-1:0]        in_val = '0;
    logic [TAG_W-1:0]          in_tag = '0;
    logic [CHUNK_W-1:0]        out_val;
    logic [TAG_W-1:0]          out_tag;
    logic                      ready;
    logic                      busy_err;
    logic                      core_start;
    logic [OP_W-1:0]           core_op;
    logic [NUM_OPS*DATA_W-1:0] core_operands;
    logic                      core_done;
    logic [DATA_W-1:0]         core_result;

    fpu_serial_frontend #(
        .CHUNK_W (CHUNK_W),
        .DATA_W  (DATA_W),
        .NUM_OPS (NUM_OPS),
        .TAG_W   (TAG_W),
        .OP_W    (OP_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_val        (in_val),
        .in_tag        (in_tag),
        .out_val       (out_val),
        .out_tag       (out_tag),
        .ready         (ready),
        .busy_err      (busy_err),
        .core_start    (core_start),
        .core_op       (core_op),
        .core_operands (core_operands),
        .core_done     (core_done),
        .core_result   (core_result)
    );

    initial forever #5 clock = ~clock;

    // Cycle n spans rising edge n to rising edge n+1.
    int cyc = 0;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [DATA_W-1:0]         m_opnd [NUM_OPS];
    int                        busy_from, free_cycle, hold_at;
    bit                        err_prev, err_new;
    logic [OP_W-1:0]           op_prev, op_new;
    logic [NUM_OPS*DATA_W-1:0] ops_prev, ops_new;
    bit                        launch_pending;
    int                        launch_q [$];
    chunk_t                    chunk_q [$];
    bit                        mon_en = 1'b0;
    bit                        fixed_mode = 1'b0;
    int                        fixed_lat = 3;
    logic [DATA_W-1:0]         fixed_res = '0;
    bit                        stray_req = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit exp_ready(input int c);
        return (c < busy_from) || (c >= free_cycle);
    endfunction

    function automatic bit exp_err(input int c);
        return (c >= hold_at) ? err_new : err_prev;
    endfunction

    function automatic logic [OP_W-1:0] exp_op(input int c);
        return (c >= hold_at) ? op_new : op_prev;
    endfunction

    function automatic logic [NUM_OPS*DATA_W-1:0] exp_ops(input int c);
        return (c >= hold_at) ? ops_new : ops_prev;
    endfunction

    function automatic logic [NUM_OPS*DATA_W-1:0] pack_opnds();
        logic [NUM_OPS*DATA_W-1:0] v;
        for (int k = 0; k < NUM_OPS; k++) v[k*DATA_W +: DATA_W] = m_opnd[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_OPS; k++) m_opnd[k] = '0;
        busy_from = 0;
        free_cycle = 0;
        hold_at = 0;
        err_prev = 1'b0;
        err_new = 1'b0;
        op_prev = '0;
        op_new = '0;
        ops_prev = '0;
        ops_new = '0;
        launch_pending = 1'b0;
        launch_q.delete();
        chunk_q.delete();
    endtask

    // Present one bus word for one cycle and advance the model accordingly.
    task automatic drive(input logic [TAG_W-1:0] tag, input logic [CHUNK_W-1:0] val);
        int idx;
        @(posedge clock);
        #1;
        in_tag = tag;
        in_val = val;
        idx = int'(tag) - 1;
        if (idx >= 0 && idx < NUM_OPS) begin
            m_opnd[idx] = DATA_W'(m_opnd[idx] * (2 ** CHUNK_W) + val);
        end else if (tag == T_EXEC) begin
            err_prev = exp_err(cyc);
            op_prev  = exp_op(cyc);
            ops_prev = exp_ops(cyc);
            if (exp_ready(cyc)) begin
                err_new = 1'b0;
                op_new = val[OP_W-1:0];
                ops_new = pack_opnds();
                busy_from = cyc + 1;
                free_cycle = BIG;
                launch_pending = 1'b1;
                launch_q.push_back(cyc + 1);
            end else begin
                err_new = 1'b1;
                op_new = op_prev;
                ops_new = ops_prev;
            end
            hold_at = cyc + 1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            if (exp_ready(cyc)) return;
            drive('0, CHUNK_W'($urandom));
        end
        check("wait_idle_timeout", ready, 1);
    endtask

    // Core model: answers each launch after a few cycles with a result.
    initial begin
        int lat;
        logic [DATA_W-1:0] res;
        chunk_t ch;
        core_done = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clock);
            if (stray_req) begin
                stray_req = 1'b0;
                @(posedge clock);
                #1;
                core_done = 1'b1;
                core_result = 16'hBEEF;
                @(posedge clock);
                #1;
                core_done = 1'b0;
            end else if (!reset && core_start && launch_pending) begin
                launch_pending = 1'b0;
                lat = fixed_mode ? fixed_lat : int'($urandom_range(1, 4));
                res = fixed_mode ? fixed_res : DATA_W'($urandom);
                repeat (lat) @(posedge clock);
                #1;
                core_done = 1'b1;
                core_result = res;
                for (int i = 0; i < CHUNKS; i++) begin
                    ch.cyc = cyc + 1 + i;
                    ch.val = CHUNK_W'(res >> (DATA_W - CHUNK_W * (i + 1)));
                    ch.tag = (i == CHUNKS - 1) ? TAG_W'(2) : TAG_W'(1);
                    chunk_q.push_back(ch);
                end
                free_cycle = cyc + CHUNKS + 1;
                @(posedge clock);
                #1;
                core_done = 1'b0;
            end
        end
    end

    // Monitor: compares DUT outputs against the model on every falling edge.
    initial begin
        int lc;
        chunk_t ch;
        forever begin
            @(negedge clock);
            if (mon_en && !reset) begin
                check("ready", ready, exp_ready(cyc));
                check("busy_err", busy_err, exp_err(cyc));
                check("core_op", core_op, exp_op(cyc));
                check("core_operands", core_operands, exp_ops(cyc));
                if (core_start) begin
                    if (launch_q.size() == 0) begin
                        check("unexpected_start", core_start, 0);
                    end else begin
                        lc = launch_q.pop_front();
                        check("start_cycle", cyc, lc);
                    end
                end else if (launch_q.size() > 0 && launch_q[0] <= cyc) begin
                    check("missed_start", core_start, 1);
                    void'(launch_q.pop_front());
                end
                if (out_tag != '0) begin
                    if (chunk_q.size() == 0) begin
                        check("unexpected_chunk", out_tag, 0);
                    end else begin
                        ch = chunk_q.pop_front();
                        check("chunk_cycle", cyc, ch.cyc);
                        check("chunk_val", out_val, ch.val);
                        check("chunk_tag", out_tag, ch.tag);
                    end
                end else begin
                    check("idle_out_val", out_val, 0);
                    if (chunk_q.size() > 0 && chunk_q[0].cyc <= cyc) begin
                        check("missed_chunk", out_tag, chunk_q[0].tag);
                        void'(chunk_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int r;
        model_reset();

        // Reset held for 3 cycles.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", ready, 1);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_val", out_val, 0);
        check("rst_core_start", core_start, 0);
        check("rst_busy_err", busy_err, 0);
        check("rst_core_op", core_op, 0);
        check("rst_core_operands", core_operands, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // Basic operation with a fixed-latency zero result.
        fixed_mode = 1'b1;
        fixed_lat = 3;
        fixed_res = '0;
        drive(1, 8'h4E);
        drive(1, 8'h54);
        drive(2, 8'h4E);
        drive(2, 8'h54);
        drive(T_EXEC, 8'h02);
        wait_idle();
        fixed_mode = 1'b0;

        // Over-length load: the last two chunks win.
        drive(1, 8'h12);
        drive(1, 8'h34);
        drive(1, 8'h56);
        drive(T_EXEC, 8'h09);
        wait_idle();

        // Reject while busy, load during busy, then a clean relaunch.
        fixed_mode = 1'b1;
        fixed_lat = 4;
        fixed_res = 16'hC3A5;
        drive(T_EXEC, 8'h05);
        drive('0, 8'h00);
        drive(T_EXEC, 8'h0A);
        drive(2, 8'hAB);
        drive(2, 8'hCD);
        wait_idle();
        fixed_mode = 1'b0;
        drive(T_EXEC, 8'h07);
        wait_idle();

        // Reset during SEND, then a stray core_done.
        drive(T_EXEC, 8'h03);
        for (int i = 0; i < 20 && chunk_q.size() == 0; i++) drive('0, 8'h00);
        if (chunk_q.size() == 0) begin
            check("reset_test_launch", launch_pending, 0);
        end else begin
            t = chunk_q[0].cyc;
            while (cyc < t) drive('0, 8'h00);
            @(posedge clock);
            #1;
            reset = 1'b1;
            in_tag = '0;
            model_reset();
            @(negedge clock);
            check("abort_out_tag", out_tag, 0);
            check("abort_out_val", out_val, 0);
            check("abort_ready", ready, 1);
            check("abort_core_start", core_start, 0);
            @(posedge clock);
            #1;
            reset = 1'b0;
            stray_req = 1'b1;
            repeat (6) drive('0, 8'h00);
        end

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45)      drive(TAG_W'($urandom_range(1, NUM_OPS)), CHUNK_W'($urandom));
            else if (r < 60) drive(T_EXEC, CHUNK_W'($urandom));
            else             drive('0, CHUNK_W'($urandom));
        end
        wait_idle();
        repeat (4) drive('0, 8'h00);

        check("launch_q_drained", launch_q.size(), 0);
        check("chunk_q_drained", chunk_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
